// File: rtl/nvm_neuron_core_param.sv
// Wishbone bridge to NUM_OF_MACRO X1 synapse macros with one saturating integrate-and-fire
// neuron per macro. Optional leak term is compiled in when NVM_NEURON_LEAK_EN is defined.
module nvm_neuron_core_param #(
    parameter int         NUM_OF_MACRO   = 4,
    parameter int         STIM_W         = 12,
    parameter int         POT_W          = 16,
    parameter int         THRESHOLD_INIT = 100,
    parameter int         LEAK_SHIFT     = 4,
    parameter logic [7:0] MEM_HIGH       = 8'hFF,
    parameter logic [7:0] MEM_LOW        = 8'h00
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    output logic [31:0]                wbs_dat_o,
    output logic                       wbs_ack_o,
    input  logic [32*NUM_OF_MACRO-1:0] slave_dat_i,
    input  logic [NUM_OF_MACRO-1:0]    slave_ack_i,
    output logic                       slave_stb_o,
    output logic                       slave_cyc_o,
    output logic                       slave_we_o,
    output logic [32*NUM_OF_MACRO-1:0] slave_dat_o,
    output logic [1:0]                 fsm_state
);

    // Handshake: a master request (stb&cyc) is held until the single-cycle wbs_ack_o pulse;
    // the edge that ends the ack cycle is the one that commits writes and integration.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SYN_WAIT  = 2'd1,
        SYN_DONE  = 2'd2,
        LOCAL_ACK = 2'd3
    } state_t;

    localparam logic [3:0] REG_SYN    = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h1;
    localparam logic [3:0] REG_PIC    = 4'h2;
    localparam logic [3:0] REG_THR    = 4'h3;

    localparam logic signed [POT_W:0] V_MAX = {2'b00, {(POT_W-1){1'b1}}};
    localparam logic signed [POT_W:0] V_MIN = {2'b11, {(POT_W-1){1'b0}}};

    state_t                    state;
    logic [3:0]                region;
    logic [3:0]                local_region;
    logic [NUM_OF_MACRO-1:0]   ack_seen;
    logic [NUM_OF_MACRO-1:0]   connection;
    logic [NUM_OF_MACRO-1:0]   conn_next;
    logic                      all_acked;
    logic signed [POT_W-1:0]   v     [NUM_OF_MACRO];
    logic signed [POT_W-1:0]   v_int [NUM_OF_MACRO];
    logic signed [POT_W-1:0]   threshold;
    logic [NUM_OF_MACRO-1:0]   spike;
    logic [15:0]               pic_cnt;
    logic signed [POT_W:0]     mag;
    logic signed [POT_W:0]     stim;
    logic [31:0]               local_rdata;
    logic                      unused;

    assign unused = ^{wbs_sel_i, wbs_adr_i, slave_dat_i, wbs_dat_i, 32'(LEAK_SHIFT)};

    assign region    = wbs_adr_i[15:12];
    assign fsm_state = state;

    assign slave_stb_o = (state == SYN_WAIT) && wbs_stb_i;
    assign slave_cyc_o = (state == SYN_WAIT) && wbs_cyc_i;
    assign slave_we_o  = (state == SYN_WAIT) && wbs_we_i;

    always_comb begin
        slave_dat_o = '0;
        for (int k = 0; k < NUM_OF_MACRO; k++) begin
            slave_dat_o[32*k +: 32] = {wbs_dat_i[31:8], wbs_dat_i[k] ? MEM_HIGH : MEM_LOW};
        end
    end

    // Connection bit is taken only from a macro's first ack of the transaction.
    always_comb begin
        conn_next = connection;
        for (int k = 0; k < NUM_OF_MACRO; k++) begin
            if (slave_ack_i[k] && !ack_seen[k]) begin
                conn_next[k] = slave_dat_i[32*k];
            end
        end
    end

    assign all_acked = &(ack_seen | slave_ack_i);

    assign mag  = {{(POT_W+1-STIM_W){1'b0}}, wbs_dat_i[STIM_W-1:0]};
    assign stim = wbs_dat_i[20] ? -mag : mag;

    function automatic logic signed [POT_W-1:0] sat(input logic signed [POT_W:0] x);
        if (x > V_MAX) begin
            return V_MAX[POT_W-1:0];
        end else if (x < V_MIN) begin
            return V_MIN[POT_W-1:0];
        end
        return x[POT_W-1:0];
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_OF_MACRO; k++) begin
            v_int[k] = v[k];
`ifdef NVM_NEURON_LEAK_EN
            v_int[k] = sat({v[k][POT_W-1], v[k]} - {v[k][POT_W-1], (v[k] >>> LEAK_SHIFT)}
                           + (connection[k] ? stim : '0));
`else
            if (connection[k]) begin
                v_int[k] = sat({v[k][POT_W-1], v[k]} + stim);
            end
`endif
        end
    end

    always_comb begin
        local_rdata = '0;
        case (region)
            REG_STATUS: local_rdata = {pic_cnt, 16'(spike)};
            REG_THR:    local_rdata = 32'(threshold);
            default:    local_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            local_region <= '0;
            ack_seen     <= '0;
            connection   <= '0;
            spike        <= '0;
            pic_cnt      <= '0;
            threshold    <= POT_W'(THRESHOLD_INIT);
            for (int k = 0; k < NUM_OF_MACRO; k++) begin
                v[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    wbs_ack_o <= 1'b0;
                    if (wbs_stb_i && wbs_cyc_i) begin
                        local_region <= region;
                        if (region == REG_SYN) begin
                            state      <= SYN_WAIT;
                            ack_seen   <= '0;
                            connection <= '0;
                        end else begin
                            state     <= LOCAL_ACK;
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= local_rdata;
                        end
                    end
                end
                SYN_WAIT: begin
                    if (!wbs_cyc_i) begin
                        state    <= IDLE;
                        ack_seen <= '0;
                    end else begin
                        ack_seen   <= ack_seen | slave_ack_i;
                        connection <= conn_next;
                        if (all_acked) begin
                            state     <= SYN_DONE;
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= 32'(conn_next);
                        end
                    end
                end
                SYN_DONE: begin
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= '0;
                    ack_seen  <= '0;
                    state     <= IDLE;
                    if (!wbs_we_i) begin
                        for (int k = 0; k < NUM_OF_MACRO; k++) begin
                            v[k] <= v_int[k];
                        end
                    end
                end
                LOCAL_ACK: begin
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= '0;
                    state     <= IDLE;
                    if (wbs_we_i) begin
                        if (local_region == REG_PIC) begin
                            for (int k = 0; k < NUM_OF_MACRO; k++) begin
                                spike[k] <= (v[k] >= threshold);
                                v[k]     <= '0;
                            end
                            pic_cnt <= pic_cnt + 16'd1;
                        end else if (local_region == REG_THR) begin
                            threshold <= wbs_dat_i[POT_W-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nvm_neuron_core_param.sv
// Bench for nvm_neuron_core_param: directed steps plus randomized traffic checked against
// an integer model of the neuron array, threshold, spikes and picture counter.
module tb_nvm_neuron_core_param;

    localparam int N          = 4;
    localparam int STIM_W     = 12;
    localparam int LEAK_SHIFT = 4;
    localparam int VMAX       = 32767;
    localparam int VMIN       = -32768;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i;
    logic            wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]      wbs_sel_i;
    logic [31:0]     wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic            wbs_ack_o;
    logic [32*N-1:0] slave_dat_i;
    logic [N-1:0]    slave_ack_i;
    logic            slave_stb_o, slave_cyc_o, slave_we_o;
    logic [32*N-1:0] slave_dat_o;
    logic [1:0]      fsm_state;

    always #5 wb_clk_i = ~wb_clk_i;

    nvm_neuron_core_param dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
        .slave_dat_i(slave_dat_i), .slave_ack_i(slave_ack_i),
        .slave_stb_o(slave_stb_o), .slave_cyc_o(slave_cyc_o), .slave_we_o(slave_we_o),
        .slave_dat_o(slave_dat_o), .fsm_state(fsm_state)
    );

    int           errors = 0;
    int           checks = 0;
    int           vm [N];
    int           thr;
    int           pic;
    logic [N-1:0] spk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int x);
        if (x > VMAX) return VMAX;
        if (x < VMIN) return VMIN;
        return x;
    endfunction

`ifdef NVM_NEURON_LEAK_EN
    // Floor division by 2^LEAK_SHIFT.
    function automatic int leak_of(input int x);
        int d;
        d = 1 << LEAK_SHIFT;
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction
`endif

    task automatic model_integrate(input logic [N-1:0] conn, input int m, input bit neg);
        int s;
        s = neg ? -m : m;
        for (int k = 0; k < N; k++) begin
`ifdef NVM_NEURON_LEAK_EN
            vm[k] = clamp(vm[k] - leak_of(vm[k]) + (conn[k] ? s : 0));
`else
            if (conn[k]) vm[k] = clamp(vm[k] + s);
`endif
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) vm[k] = 0;
        thr = 100;
        pic = 0;
        spk = '0;
    endtask

    task automatic check_v(input string tag);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_v%0d", tag, k), 32'(dut.v[k]), 32'(vm[k]));
        end
    endtask

    task automatic bus_idle();
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic local_access(input logic [31:0] adr, input bit wr_en, input logic [31:0] dat,
                                input logic [31:0] exp_rd);
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = wr_en;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        @(negedge wb_clk_i);
        check("local_ack", {31'b0, wbs_ack_o}, 32'd1);
        if (!wr_en) check($sformatf("local_rd_%h", adr), wbs_dat_o, exp_rd);
        @(negedge wb_clk_i);
        check("local_ack_drop", {31'b0, wbs_ack_o}, 32'd0);
        bus_idle();
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp_rd);
        local_access(adr, 1'b0, $urandom, exp_rd);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        local_access(adr, 1'b1, dat, 32'd0);
    endtask

    task automatic pic_done();
        wr(32'h0000_2000, $urandom);
        for (int k = 0; k < N; k++) begin
            spk[k] = (vm[k] >= thr);
            vm[k]  = 0;
        end
        pic = (pic + 1) % 65536;
    endtask

    function automatic logic [31:0] status_exp();
        return {16'(pic), 12'b0, spk};
    endfunction

    // dly holds one 4-bit ack delay per macro; rep makes a macro ack again one cycle later
    // with inverted data, which must not alter its connection bit.
    task automatic syn_access(input bit wr_en, input logic [31:0] dat, input logic [N-1:0] conn,
                              input logic [4*N-1:0] dly, input logic [N-1:0] rep);
        int          c, ack_c, maxd, dk;
        bit          got;
        logic [31:0] r;
        maxd = 0;
        for (int k = 0; k < N; k++) if (int'(dly[4*k +: 4]) > maxd) maxd = int'(dly[4*k +: 4]);
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = wr_en;
        wbs_adr_i = $urandom & 32'hFFFF_0FFF;
        wbs_dat_i = dat;
        #1 check("slave_stb_idle", {31'b0, slave_stb_o}, 32'd0);
        c = 0;
        got = 1'b0;
        ack_c = -1;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) begin
                got = 1'b1;
                ack_c = c;
            end else if (slave_stb_o) begin
                if (c == 0) begin
                    check("slave_cyc", {31'b0, slave_cyc_o}, 32'd1);
                    check("slave_we", {31'b0, slave_we_o}, {31'b0, wr_en});
                    for (int k = 0; k < N; k++) begin
                        check($sformatf("slave_dat%0d", k), slave_dat_o[32*k +: 32],
                              {dat[31:8], dat[k] ? 8'hFF : 8'h00});
                    end
                end
                for (int k = 0; k < N; k++) begin
                    dk = int'(dly[4*k +: 4]);
                    r = $urandom;
                    r[0] = (c == dk) ? conn[k] : ~conn[k];
                    slave_ack_i[k] = (c == dk) || (rep[k] && c == dk + 1);
                    slave_dat_i[32*k +: 32] = r;
                end
                c++;
            end
        end
        check("syn_ack_seen", {31'b0, got}, 32'd1);
        check("syn_ack_latency", 32'(ack_c), 32'(maxd + 1));
        check("syn_rdata", wbs_dat_o, 32'(conn));
        check("slave_stb_done", {31'b0, slave_stb_o}, 32'd0);
        slave_ack_i = '0;
        @(negedge wb_clk_i);
        check("syn_ack_drop", {31'b0, wbs_ack_o}, 32'd0);
        bus_idle();
        if (!wr_en) model_integrate(conn, int'(dat[STIM_W-1:0]), dat[20]);
    endtask

    function automatic logic [31:0] stim_word(input int m, input bit neg);
        logic [31:0] d;
        d = $urandom;
        d[STIM_W-1:0] = STIM_W'(m);
        d[20] = neg;
        return d;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [N-1:0]   rc;
    logic [4*N-1:0] rd_dly;
    int             op, t_val;

    initial begin
        wb_rst_i    = 1'b1;
        wbs_sel_i   = 4'hF;
        wbs_adr_i   = '0;
        wbs_dat_i   = '0;
        slave_ack_i = '0;
        slave_dat_i = '0;
        bus_idle();
        model_reset();
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        // Reset state
        check("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_slave_stb", {31'b0, slave_stb_o}, 32'd0);
        check("rst_fsm", 32'(fsm_state), 32'd0);
        check_v("rst");
        rd(32'h0000_3000, 32'd100);
        rd(32'h0000_1000, 32'd0);

        // Integrate and fire
        syn_access(1'b0, stim_word(60, 1'b0), 4'b0101, '0, '0);
        syn_access(1'b0, stim_word(60, 1'b0), 4'b0101, '0, '0);
        check_v("if");
`ifndef NVM_NEURON_LEAK_EN
        check("if_v0", 32'(dut.v[0]), 32'd120);
        check("if_v1", 32'(dut.v[1]), 32'd0);
`endif
        pic_done();
        rd(32'h0000_1000, 32'h0001_0005);
        check_v("after_pic");

        // Staggered acks, negative stimulus, repeated ack from macro 0
        syn_access(1'b0, stim_word(10, 1'b1), 4'b1111, {4'd4, 4'd2, 4'd2, 4'd0}, 4'b0001);
        for (int k = 0; k < N; k++) check($sformatf("stag_v%0d", k), 32'(dut.v[k]), -32'sd10);
        check_v("stag");

        // Weight programming write must not integrate
        syn_access(1'b1, $urandom, 4'b1010, {4'd1, 4'd0, 4'd3, 4'd2}, '0);
        check_v("syn_write");

        // Threshold and unmapped regions
        wr(32'h0000_3000, 32'hFFFF_FFFB);
        thr = -5;
        rd(32'h0000_3000, 32'hFFFF_FFFB);
        wr(32'h0000_7000, 32'h1234_5678);
        rd(32'h0000_5000, 32'd0);
        rd(32'h0000_2000, 32'd0);
        rd(32'h0000_3000, 32'hFFFF_FFFB);
        pic_done();
        rd(32'h0000_1000, status_exp());

        // Saturation in both directions
        for (int i = 0; i < 20; i++) syn_access(1'b0, stim_word(4095, 1'b0), 4'b0001, '0, '0);
        check("sat_pos", 32'(dut.v[0]), 32'd32767);
        for (int i = 0; i < 20; i++) syn_access(1'b0, stim_word(4095, 1'b1), 4'b0010, '0, '0);
        check("sat_neg", 32'(dut.v[1]), 32'hFFFF_8000);
        check_v("sat");

        // Abort: cyc dropped after two of four acks
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h0; wbs_dat_i = stim_word(50, 1'b0);
        @(negedge wb_clk_i);
        check("abort_slave_stb", {31'b0, slave_stb_o}, 32'd1);
        slave_ack_i = 4'b0011;
        slave_dat_i = '1;
        @(negedge wb_clk_i);
        bus_idle();
        slave_ack_i = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk_i);
            check("abort_no_ack", {31'b0, wbs_ack_o}, 32'd0);
        end
        check("abort_fsm", 32'(fsm_state), 32'd0);
        check_v("abort");
        syn_access(1'b0, stim_word(7, 1'b0), 4'b1100, {4'd0, 4'd0, 4'd3, 4'd3}, '0);
        check_v("post_abort");

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 6) begin
                rc = N'($urandom);
                for (int k = 0; k < N; k++) rd_dly[4*k +: 4] = 4'($urandom_range(0, 3));
                syn_access(op == 6, stim_word($urandom_range(0, 4095), 1'($urandom_range(0, 1))),
                           rc, rd_dly, N'($urandom));
            end else if (op == 7) begin
                pic_done();
            end else if (op == 8) begin
                t_val = $urandom_range(0, 400) - 200;
                wr(32'h0000_3000, 32'(t_val));
                thr = t_val;
                rd(32'h0000_3000, 32'(t_val));
            end else begin
                rd(32'h0000_1000, status_exp());
            end
            check_v($sformatf("rand%0d", i));
        end
        rd(32'h0000_1000, status_exp());

`ifdef NVM_NEURON_LEAK_EN
        // Leak applies to unconnected neurons on every integration read
        pic_done();
        syn_access(1'b0, stim_word(160, 1'b0), 4'b0001, '0, '0);
        check("leak_v0_160", 32'(dut.v[0]), 32'd160);
        syn_access(1'b0, stim_word(77, 1'b0), 4'b0000, '0, '0);
        check("leak_v0_150", 32'(dut.v[0]), 32'd150);
        check_v("leak");
`endif

        // Reset during SYN_WAIT restores all state and discards the access
        wr(32'h0000_3000, 32'hFFFF_FFF0);
        thr = -16;
        syn_access(1'b0, stim_word(33, 1'b0), 4'b1111, '0, '0);
        pic_done();
        syn_access(1'b0, stim_word(21, 1'b0), 4'b1111, '0, '0);
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h0; wbs_dat_i = stim_word(99, 1'b0);
        @(negedge wb_clk_i);
        check("rstmid_slave_stb", {31'b0, slave_stb_o}, 32'd1);
        slave_ack_i = 4'b0011;
        slave_dat_i = '1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        slave_ack_i = '0;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        bus_idle();
        model_reset();
        check("rstmid_ack", {31'b0, wbs_ack_o}, 32'd0);
        check("rstmid_fsm", 32'(fsm_state), 32'd0);
        check_v("rstmid");
        rd(32'h0000_3000, 32'd100);
        rd(32'h0000_1000, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
